// File: rtl/ready_generator.sv
// Bus ready generator: I/O wait states, channel-ready wait with timeout, CPU/DMA ready gating.
// Optional DMA wait state enabled by defining DMA_WAIT_STATE_EN.
module ready_generator #(
  parameter int unsigned IO_WAIT_STATES = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic io_read_n,
  input  logic io_write_n,
  input  logic memory_read_n,
  input  logic memory_write_n,
  input  logic address_enable_n,
  input  logic dma_wait_n,
  input  logic io_channel_ready,
  output logic cpu_ready,
  output logic dma_ready,
  output logic channel_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHAN, S_DONE} state_t;

  localparam bit         IO_WAIT_EN    = (IO_WAIT_STATES > 0);
  localparam logic [1:0] WAIT_LOAD     = IO_WAIT_EN ? 2'(IO_WAIT_STATES - 1) : 2'd0;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [1:0] wait_cnt;
  logic [7:0] tmo_cnt;
  logic       chrdy_m, chrdy_s;
  logic       cmd_idle_prev;
  logic       cmd_idle, io_cmd, cycle_start, fsm_ready;
`ifdef DMA_WAIT_STATE_EN
  logic       mem_cmd;
`endif

  always_comb begin
    cmd_idle    = io_read_n & io_write_n & memory_read_n & memory_write_n;
    io_cmd      = ~(io_read_n & io_write_n);
    cycle_start = cmd_idle_prev & ~cmd_idle;
    fsm_ready   = (state == S_IDLE) || (state == S_DONE);
`ifdef DMA_WAIT_STATE_EN
    mem_cmd     = ~(memory_read_n & memory_write_n);
`endif
  end

  assign cpu_ready = address_enable_n | fsm_ready;
  assign dma_ready = fsm_ready & dma_wait_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chrdy_m       <= 1'b1;
      chrdy_s       <= 1'b1;
      cmd_idle_prev <= 1'b1;
    end else begin
      chrdy_m       <= io_channel_ready;
      chrdy_s       <= chrdy_m;
      cmd_idle_prev <= cmd_idle;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      tmo_cnt         <= '0;
      channel_timeout <= 1'b0;
    end else begin
      channel_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cycle_start) begin
            // I/O decoded first so it wins over a memory command on the same edge
            if (io_cmd && !address_enable_n && IO_WAIT_EN) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
`ifdef DMA_WAIT_STATE_EN
            else if (!io_cmd && address_enable_n && mem_cmd) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
`endif
            else if (!chrdy_s) begin
              state   <= S_CHAN;
              tmo_cnt <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (cmd_idle) begin
            state <= S_IDLE;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (!chrdy_s) begin
            state   <= S_CHAN;
            tmo_cnt <= '0;
          end else begin
            state <= S_DONE;
          end
        end
        S_CHAN: begin
          if (cmd_idle) begin
            state <= S_IDLE;
          end else if (chrdy_s) begin
            state <= S_DONE;
          end else if (tmo_cnt + 8'd1 == TIMEOUT_LIMIT) begin
            state           <= S_DONE;
            channel_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (cmd_idle) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ready_generator.sv
// Bench for ready_generator: constant vector table, hand sequences for timeout/abort/reset,
// and random traffic checked against a cycle-progress model for two parameter sets.
module tb_ready_generator;

  logic clock = 1'b0;
  logic reset_n;
  logic ior, iow, mr, mw, aen, dwn, chrdy;
  logic cpu_a, dma_a, tmo_a, cpu_b, dma_b, tmo_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ready_generator #(.IO_WAIT_STATES(1), .TIMEOUT_CYCLES(255)) u_a (
    .clock(clock), .reset_n(reset_n),
    .io_read_n(ior), .io_write_n(iow), .memory_read_n(mr), .memory_write_n(mw),
    .address_enable_n(aen), .dma_wait_n(dwn), .io_channel_ready(chrdy),
    .cpu_ready(cpu_a), .dma_ready(dma_a), .channel_timeout(tmo_a)
  );

  ready_generator #(.IO_WAIT_STATES(3), .TIMEOUT_CYCLES(4)) u_b (
    .clock(clock), .reset_n(reset_n),
    .io_read_n(ior), .io_write_n(iow), .memory_read_n(mr), .memory_write_n(mw),
    .address_enable_n(aen), .dma_wait_n(dwn), .io_channel_ready(chrdy),
    .cpu_ready(cpu_b), .dma_ready(dma_b), .channel_timeout(tmo_b)
  );

  // Model: phase 0 = no cycle, 1 = wait states, 2 = waiting on channel, 3 = cycle complete.
  int ws  [2] = '{1, 3};
  int tlim[2] = '{255, 4};
  int m_phase[2], m_wait_left[2], m_chan_cycles[2];
  bit m_s1[2], m_s2[2], m_prev_idle[2], m_pulse[2];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_wait_left[k] = 0; m_chan_cycles[k] = 0;
      m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_prev_idle[k] = 1'b1; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic settle(input int k);
    m_phase[k] = m_s2[k] ? 3 : 2;
    m_chan_cycles[k] = 0;
  endtask

  task automatic model_edge(input int k);
    bit idle_now, start, io_any;
    idle_now = ior & iow & mr & mw;
    io_any   = !(ior & iow);
    start    = m_prev_idle[k] && !idle_now;
    m_pulse[k] = 1'b0;
    case (m_phase[k])
      0: if (start) begin
        if (io_any && !aen && ws[k] > 0) begin
          m_phase[k] = 1; m_wait_left[k] = ws[k];
        end
`ifdef DMA_WAIT_STATE_EN
        else if (!io_any && aen && !(mr & mw)) begin
          m_phase[k] = 1; m_wait_left[k] = 1;
        end
`endif
        else settle(k);
      end
      1: if (idle_now) m_phase[k] = 0;
         else begin
           m_wait_left[k]--;
           if (m_wait_left[k] == 0) settle(k);
         end
      2: if (idle_now) m_phase[k] = 0;
         else if (m_s2[k]) m_phase[k] = 3;
         else begin
           m_chan_cycles[k]++;
           if (m_chan_cycles[k] == tlim[k]) begin
             m_phase[k] = 3; m_pulse[k] = 1'b1;
           end
         end
      default: if (idle_now) m_phase[k] = 0;
    endcase
    m_s2[k] = m_s1[k];
    m_s1[k] = chrdy;
    m_prev_idle[k] = idle_now;
  endtask

  task automatic tick();
    bit rdy;
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    rdy = (m_phase[0] == 0) || (m_phase[0] == 3);
    chk("model_cpu_a", cpu_a, aen | rdy);
    chk("model_dma_a", dma_a, rdy & dwn);
    chk("model_tmo_a", tmo_a, m_pulse[0]);
    rdy = (m_phase[1] == 0) || (m_phase[1] == 3);
    chk("model_cpu_b", cpu_b, aen | rdy);
    chk("model_dma_b", dma_b, rdy & dwn);
    chk("model_tmo_b", tmo_b, m_pulse[1]);
  endtask

  task automatic idle_bus();
    ior = 1'b1; iow = 1'b1; mr = 1'b1; mw = 1'b1;
  endtask

  typedef struct packed {
    logic ior, iow, mr, mw, aen, chrdy, dwn;
    logic cpu, dma, tmo;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int lat, run_len;

    vecs[0]  = 10'b1111_011_110;
    vecs[1]  = 10'b0111_011_000;  // CPU I/O read: one wait state
    vecs[2]  = 10'b0111_011_110;
    vecs[3]  = 10'b0111_011_110;
    vecs[4]  = 10'b1111_011_110;
    vecs[5]  = 10'b1111_001_110;
    vecs[6]  = 10'b1111_001_110;
    vecs[7]  = 10'b1110_001_000;  // memory write, channel not ready
    vecs[8]  = 10'b1110_001_000;
    vecs[9]  = 10'b1110_011_000;
    vecs[10] = 10'b1110_011_000;
    vecs[11] = 10'b1110_011_110;
    vecs[12] = 10'b1111_011_110;
`ifdef DMA_WAIT_STATE_EN
    vecs[13] = 10'b1101_111_100;
`else
    vecs[13] = 10'b1101_111_110;  // DMA memory read, no wait
`endif
    vecs[14] = 10'b1101_110_100;
    vecs[15] = 10'b1111_111_110;
    vecs[16] = 10'b1001_011_000;  // I/O and memory together: I/O wins
    vecs[17] = 10'b1001_011_110;
    vecs[18] = 10'b1111_011_110;
    vecs[19] = 10'b1011_111_110;  // DMA-owned I/O: no CPU wait state
    vecs[20] = 10'b1111_111_110;

    // Reset values with a command and channel-not-ready present
    reset_n = 1'b0; idle_bus(); ior = 1'b0; chrdy = 1'b0; aen = 1'b0; dwn = 1'b1;
    #2;
    chk("rst_cpu_a", cpu_a, 1'b1); chk("rst_dma_a", dma_a, 1'b1); chk("rst_tmo_a", tmo_a, 1'b0);
    chk("rst_cpu_b", cpu_b, 1'b1); chk("rst_tmo_b", tmo_b, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    idle_bus(); chrdy = 1'b1;
    reset_n = 1'b1;
    model_reset();
    repeat (3) tick();

    for (int i = 0; i < 21; i++) begin
      ior = vecs[i].ior; iow = vecs[i].iow; mr = vecs[i].mr; mw = vecs[i].mw;
      aen = vecs[i].aen; chrdy = vecs[i].chrdy; dwn = vecs[i].dwn;
      tick();
      chk($sformatf("vec%0d_cpu", i), cpu_a, vecs[i].cpu);
      chk($sformatf("vec%0d_dma", i), dma_a, vecs[i].dma);
      chk($sformatf("vec%0d_tmo", i), tmo_a, vecs[i].tmo);
    end

    // Channel ready stuck low: timeout pulse 255 cycles after channel wait begins
    idle_bus(); aen = 1'b0; dwn = 1'b1; chrdy = 1'b0;
    repeat (2) tick();
    mr = 1'b0;
    tick();
    chk("tmo_entry_cpu", cpu_a, 1'b0);
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (tmo_a === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk_int("tmo_latency", lat, 255);
    chk("tmo_cpu_same_cycle", cpu_a, 1'b1);
    tick();
    chk("tmo_single_pulse", tmo_a, 1'b0);
    idle_bus(); chrdy = 1'b1;
    repeat (3) tick();

    // Bus abort during I/O wait states (3 wait states)
    iow = 1'b0;
    tick();
    chk("abort_wait1_cpu", cpu_b, 1'b0);
    tick();
    chk("abort_wait2_cpu", cpu_b, 1'b0);
    iow = 1'b1;
    tick();
    chk("abort_cpu", cpu_b, 1'b1);
    chk("abort_tmo", tmo_b, 1'b0);
    tick();
    chk("abort_after_tmo", tmo_b, 1'b0);

    // Reset mid-wait abandons the cycle
    iow = 1'b0;
    tick();
    chk("midrst_wait_cpu", cpu_b, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cpu", cpu_b, 1'b1);
    chk("midrst_tmo", tmo_b, 1'b0);
    iow = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      chk("postrst_cpu", cpu_b, 1'b1);
    end

    // Random traffic against the model
    run_len = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) begin
        int r;
        r = $urandom_range(9);
        idle_bus();
        if (r < 4) aen = 1'($urandom_range(1));
        else if (r == 4) ior = 1'b0;
        else if (r == 5) iow = 1'b0;
        else if (r == 6) mr = 1'b0;
        else if (r == 7) mw = 1'b0;
        else if (r == 8) begin ior = 1'b0; mw = 1'b0; end
        else begin iow = 1'b0; mr = 1'b0; end
      end
      if (run_len > 0) begin
        run_len--; chrdy = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        run_len = $urandom_range(8, 1); chrdy = 1'b0;
      end else begin
        chrdy = 1'b1;
      end
      dwn = ($urandom_range(7) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
